hex_operand_loader: RTL and testbench

HEX_OPERAND_LOADER -- requirements
Module: hex_operand_loader

---
 rtl/hex_operand_loader.sv | 138 +++++++++++++
 tb/tb_hex_operand_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hex_operand_loader.sv
// hex_operand_loader: assembles one W-bit operand from a line of ASCII hex
// characters (UART receive stream) and offers it to a consumer with a
// valid/ready handshake. Malformed or overlong lines are dropped and
// flagged with a one-cycle err pulse once their terminator arrives.
// Optional build macro: HEX_UPPER_EN also accepts upper-case 'A'..'F'.
module hex_operand_loader #(
  parameter  int W    = 32,
  localparam int MAXD = W / 4,
  localparam int CW   = $clog2(MAXD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          op_valid,
  output logic [W-1:0]  op_data,
  input  logic          op_ready,
  output logic          err,
  output logic [CW-1:0] digit_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, ERR} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  op_data_q, op_data_d;
  logic          op_valid_q, op_valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;

  logic          is_dig, is_term, is_sp, take;
  logic [7:0]    diff;
  logic [3:0]    nib;

  // Character classification and digit-to-nibble conversion
  always_comb begin
    is_dig  = 1'b0;
    diff    = 8'h00;
    is_term = (in_data == 8'h0D) || (in_data == 8'h0A);
    is_sp   = (in_data == 8'h20);
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      is_dig = 1'b1;
      diff   = in_data - 8'h30;
    end else if (in_data >= 8'h61 && in_data <= 8'h66) begin
      is_dig = 1'b1;
      diff   = in_data - 8'h57;
`ifdef HEX_UPPER_EN
    end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
      is_dig = 1'b1;
      diff   = in_data - 8'h37;
`endif
    end
    nib = diff[3:0];
  end

  // rdy_q holds in_ready low until the first edge after reset release
  assign in_ready  = rdy_q && (state_q != HOLD);
  assign take      = in_valid && in_ready;
  assign op_valid  = op_valid_q;
  assign op_data   = op_data_q;
  assign err       = err_q;
  assign digit_cnt = cnt_q;

  // Next-state logic: one transition per accepted character or op handshake
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    op_data_d  = op_data_q;
    op_valid_d = op_valid_q;
    err_d      = 1'b0;
    rdy_d      = 1'b1;
    case (state_q)
      IDLE: if (take) begin
        if (is_dig) begin
          acc_d   = W'(nib);
          cnt_d   = CW'(1);
          state_d = LOAD;
        end else if (!is_term && !is_sp) begin
          state_d = ERR;
        end
      end
      LOAD: if (take) begin
        if (is_dig) begin
          if (cnt_q == CW'(MAXD)) begin
            state_d = ERR;            // overflow: keep acc, wait for terminator
          end else begin
            acc_d = {acc_q[W-5:0], nib};
            cnt_d = cnt_q + CW'(1);
          end
        end else if (is_term) begin
          op_data_d  = acc_q;
          op_valid_d = 1'b1;
          state_d    = HOLD;
        end else if (!is_sp) begin
          state_d = ERR;
        end
      end
      HOLD: if (op_ready) begin
        op_valid_d = 1'b0;
        acc_d      = '0;
        cnt_d      = '0;
        state_d    = IDLE;
      end
      ERR: if (take && is_term) begin
        err_d   = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any partial or pending operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      op_data_q  <= '0;
      op_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      op_data_q  <= op_data_d;
      op_valid_q <= op_valid_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
    end
  end

endmodule

// File: tb/tb_hex_operand_loader.sv
// Directed bench for hex_operand_loader (W=32): hand-computed operands,
// error pulses, backpressure hold, space/empty lines and async reset.
module tb_hex_operand_loader;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic         op_valid;
  logic [W-1:0] op_data;
  logic         op_ready = 1'b0;
  logic         err;
  logic [3:0]   digit_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  hex_operand_loader #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .err(err), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte; returns #1 after the edge that accepted it
  task automatic send(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = c;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    chk("rst_op_data",  64'(op_data),  64'd0);
    chk("rst_err",      64'(err),      64'd0);
    chk("rst_cnt",      64'(digit_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 64'(in_ready), 64'd0);
    tick();
    chk("rdy_after_edge", 64'(in_ready), 64'd1);

    // "1f\r" with op_ready high
    op_ready = 1'b1;
    send("1");
    chk("1f_cnt1", 64'(digit_cnt), 64'd1);
    send("f");
    chk("1f_cnt2", 64'(digit_cnt), 64'd2);
    send(8'h0D);
    chk("1f_valid", 64'(op_valid), 64'd1);
    chk("1f_data",  64'(op_data),  64'h1F);
    chk("1f_err",   64'(err),      64'd0);
    tick();
    chk("1f_valid_drop", 64'(op_valid), 64'd0);
    chk("1f_err2",       64'(err),      64'd0);

    // "deadbeef\n" with 5 cycles of backpressure; exactly MAXD digits
    op_ready = 1'b0;
    send_str("deadbeef");
    chk("db_cnt8", 64'(digit_cnt), 64'd8);
    send(8'h0A);
    for (int i = 0; i < 5; i++) begin
      chk("db_hold_valid", 64'(op_valid), 64'd1);
      chk("db_hold_data",  64'(op_data),  64'hDEADBEEF);
      chk("db_hold_rdy",   64'(in_ready), 64'd0);
      tick();
    end
    @(negedge clk);
    op_ready = 1'b1;
    tick();
    chk("db_release",     64'(op_valid), 64'd0);
    chk("db_release_rdy", 64'(in_ready), 64'd1);
    chk("db_release_cnt", 64'(digit_cnt), 64'd0);

    // "123456789\r": overflow
    send_str("123456789");
    chk("ovf_no_valid", 64'(op_valid), 64'd0);
    chk("ovf_no_err_yet", 64'(err), 64'd0);
    send(8'h0D);
    chk("ovf_err",      64'(err),       64'd1);
    chk("ovf_no_valid2", 64'(op_valid), 64'd0);
    chk("ovf_cnt0",     64'(digit_cnt), 64'd0);
    tick();
    chk("ovf_err_pulse", 64'(err), 64'd0);

    // "1g2\r" then "7\r"
    send_str("1g2");
    send(8'h0D);
    chk("bad_err",   64'(err),      64'd1);
    chk("bad_valid", 64'(op_valid), 64'd0);
    send("7");
    chk("bad_err_gone", 64'(err), 64'd0);
    send(8'h0D);
    chk("seven_valid", 64'(op_valid), 64'd1);
    chk("seven_data",  64'(op_data),  64'h7);
    tick();

    // spaces ignored, empty line ignored
    send_str(" 1 2");
    send(8'h0D);
    chk("sp_data", 64'(op_data), 64'h12);
    tick();
    send(8'h0A);
    chk("empty_valid", 64'(op_valid), 64'd0);
    chk("empty_err",   64'(err),      64'd0);

    // upper-case digits
    send_str("AB");
    send(8'h0D);
`ifdef HEX_UPPER_EN
    chk("upper_valid", 64'(op_valid), 64'd1);
    chk("upper_data",  64'(op_data),  64'hAB);
    chk("upper_err",   64'(err),      64'd0);
`else
    chk("upper_err",   64'(err),      64'd1);
    chk("upper_valid", 64'(op_valid), 64'd0);
`endif
    tick();

    // reset mid-line after "ab"
    send_str("ab");
    chk("mid_cnt2", 64'(digit_cnt), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 64'(digit_cnt), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset while holding a pending operand
    op_ready = 1'b0;
    send_str("9");
    send(8'h0D);
    chk("hold_valid", 64'(op_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", 64'(op_valid), 64'd0);
    chk("hold_rst_data",  64'(op_data),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op_ready = 1'b1;
    send("5");
    send(8'h0D);
    chk("post_rst_valid", 64'(op_valid), 64'd1);
    chk("post_rst_data",  64'(op_data),  64'h5);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
